// File: rtl/spi_cmd_ctl.sv
// spi_cmd_ctl - SPI frame command sequencer toward the shared system bus.
//
// Watches the SPI byte buffer (rx_count, rx0..rx3), decodes the opcode in
// rx0 and issues exactly one bus read or write per frame over a req/ack
// handshake. Read data is returned on tx_byte. At frame end the byte buffer
// is cleared with a one-cycle buf_clear pulse.
//
// Optional feature macro: SPI_CMD_AUTOINC_EN
//   defined   - opcodes 0x30 (WRITE_NEXT) and 0x20 (READ_NEXT) are legal and
//               use an internal auto-incrementing address register.
//   undefined - 0x30 / 0x20 are illegal and the address register is absent.
//
// Ports:
//   sys_clk, reset_n          clock, synchronous active-low reset
//   spi_cs_n                  raw SPI chip select (asynchronous)
//   rx_count, rx0..rx3        byte buffer count and contents
//   buf_clear                 one-cycle byte buffer clear pulse
//   tx_byte                   read data returned to the host
//   bus_req/we/addr/wdata     bus request channel
//   bus_ack, bus_rdata        bus completion and read data
//   busy                      high whenever the FSM is not in IDLE
//   err                       sticky error, cleared at next frame start
module spi_cmd_ctl #(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic                  spi_cs_n,
  input  logic [2:0]            rx_count,
  input  logic [7:0]            rx0,
  input  logic [7:0]            rx1,
  input  logic [7:0]            rx2,
  input  logic [7:0]            rx3,
  output logic                  buf_clear,
  output logic [7:0]            tx_byte,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  input  logic                  bus_ack,
  input  logic [7:0]            bus_rdata,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // Last timer value before the request is abandoned; the request is then
  // high for exactly TIMEOUT cycles.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t                state_reg;
  logic                  cs_meta_reg;
  logic                  cs_s_reg;
  logic                  cs_d_reg;
  logic [7:0]            timer_reg;
  logic                  end_pending_reg;
  logic                  cs_rise;
  logic                  cs_fall;

  logic                  cmd_legal;
  logic [2:0]            cmd_need;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_wdata;

`ifdef SPI_CMD_AUTOINC_EN
  logic [ADDR_WIDTH-1:0] addr_reg;
`endif

  assign cs_rise = cs_s_reg & ~cs_d_reg;
  assign cs_fall = ~cs_s_reg & cs_d_reg;

  // Opcode decode: legality, bytes needed, and the transaction to issue.
  always_comb begin
    cmd_legal = 1'b1;
    cmd_need  = 3'd4;
    cmd_we    = 1'b0;
    cmd_addr  = ADDR_WIDTH'({rx1, rx2});
    cmd_wdata = rx3;
    case (rx0)
      8'h80: begin
        cmd_need = 3'd4;
        cmd_we   = 1'b1;
      end
      8'h40: cmd_need = 3'd3;
`ifdef SPI_CMD_AUTOINC_EN
      8'h30: begin
        cmd_need  = 3'd2;
        cmd_we    = 1'b1;
        cmd_addr  = addr_reg;
        cmd_wdata = rx1;
      end
      8'h20: begin
        cmd_need = 3'd1;
        cmd_addr = addr_reg;
      end
`endif
      default: cmd_legal = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      cs_meta_reg     <= 1'b1;
      cs_s_reg        <= 1'b1;
      cs_d_reg        <= 1'b1;
      timer_reg       <= 8'd0;
      end_pending_reg <= 1'b0;
      buf_clear       <= 1'b0;
      tx_byte         <= 8'h00;
      bus_req         <= 1'b0;
      bus_we          <= 1'b0;
      bus_addr        <= '0;
      bus_wdata       <= 8'h00;
      busy            <= 1'b0;
      err             <= 1'b0;
`ifdef SPI_CMD_AUTOINC_EN
      addr_reg        <= '0;
`endif
    end else begin
      cs_meta_reg <= spi_cs_n;
      cs_s_reg    <= cs_meta_reg;
      cs_d_reg    <= cs_s_reg;
      buf_clear   <= 1'b0;

      if (cs_fall) err <= 1'b0;

      case (state_reg)
        IDLE: begin
          // While buf_clear is high the buffer still shows the previous
          // frame's bytes; decoding them would issue a second transaction.
          if (!buf_clear && rx_count != 3'd0 && !cmd_legal) begin
            err <= 1'b1;
            if (cs_rise) begin
              buf_clear <= 1'b1;
            end else begin
              state_reg <= DONE;
              busy      <= 1'b1;
            end
          end else if (!buf_clear && cmd_legal && rx_count >= cmd_need) begin
            bus_req         <= 1'b1;
            bus_we          <= cmd_we;
            bus_addr        <= cmd_addr;
            bus_wdata       <= cmd_wdata;
            busy            <= 1'b1;
            timer_reg       <= 8'd0;
            end_pending_reg <= cs_rise;
            state_reg       <= REQ;
          end else if (cs_rise) begin
            buf_clear <= 1'b1;
          end
        end

        REQ: begin
          if (cs_rise) end_pending_reg <= 1'b1;
          if (bus_ack || timer_reg == TMO_LAST) begin
            bus_req <= 1'b0;
            if (bus_ack) begin
              if (!bus_we) tx_byte <= bus_rdata;
`ifdef SPI_CMD_AUTOINC_EN
              addr_reg <= bus_addr + ADDR_WIDTH'(1);
`endif
            end else begin
              err <= 1'b1;
            end
            // A frame that already ended while the bus cycle was running
            // is closed out right away instead of waiting in DONE.
            if (end_pending_reg || cs_rise) begin
              buf_clear       <= 1'b1;
              busy            <= 1'b0;
              end_pending_reg <= 1'b0;
              state_reg       <= IDLE;
            end else begin
              state_reg <= DONE;
            end
          end else begin
            timer_reg <= timer_reg + 8'd1;
          end
        end

        DONE: begin
          if (cs_rise) begin
            buf_clear <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctl.sv
// Testbench for spi_cmd_ctl: bus transactions are checked by a scoreboard
// queue and a monitor; frame-level results are checked inline.
module tb_spi_cmd_ctl;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic [2:0]  rx_count = 3'd0;
  logic [7:0]  rx0 = 8'h00, rx1 = 8'h00, rx2 = 8'h00, rx3 = 8'h00;
  logic        buf_clear;
  logic [7:0]  tx_byte;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ack = 1'b0;
  logic [7:0]  bus_rdata = 8'h00;
  logic        busy;
  logic        err;

  spi_cmd_ctl #(.ADDR_WIDTH(16), .TIMEOUT(255)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .spi_cs_n(spi_cs_n),
    .rx_count(rx_count), .rx0(rx0), .rx1(rx1), .rx2(rx2), .rx3(rx3),
    .buf_clear(buf_clear), .tx_byte(tx_byte),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .busy(busy), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  txn_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Responder controls (written by stimulus only)
  logic       ack_en = 1'b0;
  int         ack_delay = 2;
  logic [7:0] rdata_v = 8'h00;

  // Monitor-owned observations
  int   req_len = 0;
  int   last_len = 0;
  int   busy_cnt = 0;
  logic req_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus responder: acks ack_delay cycles after bus_req rises.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge sys_clk);
      if (bus_req && !bus_ack && ack_en) begin
        if (cnt == ack_delay) begin
          bus_ack   = 1'b1;
          bus_rdata = rdata_v;
        end else begin
          cnt++;
        end
      end else begin
        bus_ack = 1'b0;
        cnt     = 0;
      end
    end
  end

  // Monitor: compares each new bus request against the scoreboard.
  initial begin
    txn_t e;
    forever begin
      @(negedge sys_clk);
      if (bus_req && !req_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got we=%0b addr=%h expected no request", bus_we, bus_addr);
        end else begin
          e = exp_q.pop_front();
          chk("txn_we", 32'(bus_we), 32'(e.we));
          chk("txn_addr", 32'(bus_addr), 32'(e.addr));
          if (e.we) chk("txn_wdata", 32'(bus_wdata), 32'(e.wdata));
          $display("txn we=%0b addr=%h wdata=%h", bus_we, bus_addr, bus_wdata);
        end
      end
      if (bus_req) req_len++;
      else if (req_prev) begin
        last_len = req_len;
        req_len  = 0;
      end
      req_prev = bus_req;
      if (busy) busy_cnt++;
    end
  end

  task automatic frame_begin();
    @(negedge sys_clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic send(input logic [7:0] b0, b1, b2, b3, input int n);
    rx0 = b0; rx1 = b1; rx2 = b2; rx3 = b3;
    for (int i = 0; i < n; i++) begin
      rx_count = 3'(i + 1);
      repeat (2) @(negedge sys_clk);
    end
  endtask

  // Raise CS and wait (bounded) for buf_clear; emulate the buffer clear.
  task automatic frame_end(output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    @(negedge sys_clk);
    spi_cs_n = 1'b1;
    for (int k = 1; k <= 600 && !seen; k++) begin
      @(negedge sys_clk);
      if (buf_clear) begin
        rx_count = 3'd0;
        lat      = k;
        seen     = 1;
      end
    end
    chk("buf_clear_seen", 32'(seen), 32'd1);
    @(negedge sys_clk);
    chk("buf_clear_width", 32'(buf_clear), 32'd0);
    $display("frame end buf_clear latency=%0d", lat);
  endtask

  initial begin
    int lat;
    int bsnap;
    bit got;
    txn_t t;

    repeat (5) @(negedge sys_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'h00);
    chk("rst_buf_clear", 32'(buf_clear), 32'd0);
    ack_en = 1'b1;

    // WRITE 80 12 34 A5
    t.we = 1'b1; t.addr = 16'h1234; t.wdata = 8'hA5; exp_q.push_back(t);
    frame_begin();
    send(8'h80, 8'h12, 8'h34, 8'hA5, 4);
    repeat (10) @(negedge sys_clk);
    chk("wr_busy_done", 32'(busy), 32'd1);
    chk("wr_req_len", 32'(last_len), 32'd3);
    frame_end(lat);
    chk("wr_clear_latency", 32'(lat), 32'd3);
    chk("wr_err", 32'(err), 32'd0);

    // READ 40 FF FF -> 5A
    rdata_v = 8'h5A;
    t.we = 1'b0; t.addr = 16'hFFFF; t.wdata = 8'h00; exp_q.push_back(t);
    frame_begin();
    send(8'h40, 8'hFF, 8'hFF, 8'h00, 3);
    repeat (10) @(negedge sys_clk);
    chk("rd_tx_byte", 32'(tx_byte), 32'h5A);
    frame_end(lat);

    // READ_NEXT 20 -> 6B (wraps to 0000 when auto-increment exists)
    rdata_v = 8'h6B;
`ifdef SPI_CMD_AUTOINC_EN
    t.we = 1'b0; t.addr = 16'h0000; t.wdata = 8'h00; exp_q.push_back(t);
`endif
    frame_begin();
    send(8'h20, 8'h00, 8'h00, 8'h00, 1);
    repeat (10) @(negedge sys_clk);
`ifdef SPI_CMD_AUTOINC_EN
    chk("rdn_tx_byte", 32'(tx_byte), 32'h6B);
    chk("rdn_err", 32'(err), 32'd0);
`else
    chk("rdn_tx_byte", 32'(tx_byte), 32'h5A);
    chk("rdn_err", 32'(err), 32'd1);
`endif
    frame_end(lat);

    // Illegal opcode 0x11
    frame_begin();
    chk("start_clears_err", 32'(err), 32'd0);
    send(8'h11, 8'h00, 8'h00, 8'h00, 1);
    repeat (4) @(negedge sys_clk);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_busy", 32'(busy), 32'd1);
    frame_end(lat);
    chk("ill_err_sticky", 32'(err), 32'd1);

    // WRITE_NEXT 30 77 (next frame start must clear err first)
`ifdef SPI_CMD_AUTOINC_EN
    t.we = 1'b1; t.addr = 16'h0001; t.wdata = 8'h77; exp_q.push_back(t);
`endif
    frame_begin();
    chk("next_start_clears_err", 32'(err), 32'd0);
    send(8'h30, 8'h77, 8'h00, 8'h00, 2);
    repeat (10) @(negedge sys_clk);
`ifdef SPI_CMD_AUTOINC_EN
    chk("wrn_err", 32'(err), 32'd0);
`else
    chk("wrn_err", 32'(err), 32'd1);
`endif
    frame_end(lat);

    // READ with no ack: timeout after 255 cycles, CS rises mid-request
    ack_en = 1'b0;
    rdata_v = 8'hEE;
    t.we = 1'b0; t.addr = 16'h0010; t.wdata = 8'h00; exp_q.push_back(t);
    frame_begin();
    send(8'h40, 8'h00, 8'h10, 8'h00, 3);
    repeat (20) @(negedge sys_clk);
    frame_end(lat);
    chk("tmo_req_len", 32'(last_len), 32'd255);
    chk("tmo_err", 32'(err), 32'd1);
`ifdef SPI_CMD_AUTOINC_EN
    chk("tmo_tx_byte", 32'(tx_byte), 32'h6B);
`else
    chk("tmo_tx_byte", 32'(tx_byte), 32'h5A);
`endif
    chk("tmo_busy", 32'(busy), 32'd0);
    ack_en = 1'b1;

    // Short frame 80 12: no request, buf_clear, busy stays low
    bsnap = busy_cnt;
    frame_begin();
    send(8'h80, 8'h12, 8'h00, 8'h00, 2);
    repeat (10) @(negedge sys_clk);
    frame_end(lat);
    chk("short_clear_latency", 32'(lat), 32'd3);
    chk("short_busy_never", 32'(busy_cnt), 32'(bsnap));

    // Reset while in REQ
    ack_en = 1'b0;
    t.we = 1'b1; t.addr = 16'hABCD; t.wdata = 8'h01; exp_q.push_back(t);
    frame_begin();
    send(8'h80, 8'hAB, 8'hCD, 8'h01, 4);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (bus_req) got = 1;
      else @(negedge sys_clk);
    end
    chk("rstreq_req_seen", 32'(got), 32'd1);
    repeat (3) @(negedge sys_clk);
    reset_n  = 1'b0;
    spi_cs_n = 1'b1;
    rx_count = 3'd0;
    @(posedge sys_clk);
    #1;
    chk("rstreq_bus_req", 32'(bus_req), 32'd0);
    chk("rstreq_busy", 32'(busy), 32'd0);
    chk("rstreq_tx_byte", 32'(tx_byte), 32'h00);
    chk("rstreq_err", 32'(err), 32'd0);
    chk("rstreq_buf_clear", 32'(buf_clear), 32'd0);
    repeat (3) @(negedge sys_clk);
    reset_n = 1'b1;
    ack_en  = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Controller back in IDLE: a fresh WRITE goes through
    t.we = 1'b1; t.addr = 16'h0005; t.wdata = 8'h3C; exp_q.push_back(t);
    frame_begin();
    send(8'h80, 8'h00, 8'h05, 8'h3C, 4);
    repeat (10) @(negedge sys_clk);
    frame_end(lat);
    chk("post_rst_err", 32'(err), 32'd0);

    repeat (5) @(negedge sys_clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
